// File: rtl/sqrt_arbiter.sv
// Round-robin shared integer square-root engine: restoring set-bit-and-compare, one root bit per cycle.
// Optional remainder output enabled by defining SQRT_ARB_REMAINDER_EN.
module sqrt_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TC_MODE = 0,
  localparam int RW  = (WIDTH + 1) / 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RW-1:0]            res_root,
  output logic [IDW-1:0]           res_id,
  output logic                     res_neg
`ifdef SQRT_ARB_REMAINDER_EN
  , output logic [RW:0]            res_rem
`endif
);

  localparam int BW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [RW-1:0]      root_q;
  logic [IDW-1:0]     id_q, ptr_q;
  logic [BW-1:0]      b_q;
  logic               neg_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic [WIDTH-1:0]   a_sel;
  logic               tc_neg;

  // Rotating priority: offset i from ptr wins if no smaller offset already won.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    a_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_any && req_valid[j] &&
            ((int'(ptr_q) + i == j) || (int'(ptr_q) + i == j + NUM_REQ))) begin
          grant_any = 1'b1;
          grant[j]  = 1'b1;
          grant_id  = IDW'(j);
          a_sel     = req_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign tc_neg    = (TC_MODE != 0) && a_sel[WIDTH-1];
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  logic [RW-1:0]   trial, root_nxt;
  logic [2*RW-1:0] sq, a_ext;

  // 2*RW bits holds both trial^2 and the zero-extended operand without overflow.
  always_comb begin
    trial    = root_q | (RW'(1) << b_q);
    sq       = (2*RW)'(trial) * (2*RW)'(trial);
    a_ext    = (2*RW)'(a_q);
    root_nxt = (sq <= a_ext) ? trial : root_q;
  end

`ifdef SQRT_ARB_REMAINDER_EN
  logic [RW:0]     rem_q;
  logic [2*RW-1:0] rem_full;
  assign rem_full = a_ext - (2*RW)'(root_nxt) * (2*RW)'(root_nxt);
  assign res_rem  = rem_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_any) state_nxt = tc_neg ? DONE : CALC;
      CALC: if (b_q == '0) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      root_q <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
`ifdef SQRT_ARB_REMAINDER_EN
      rem_q  <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_any) begin
          a_q    <= a_sel;
          id_q   <= grant_id;
          root_q <= '0;
          b_q    <= BW'(RW - 1);
          neg_q  <= tc_neg;
`ifdef SQRT_ARB_REMAINDER_EN
          rem_q  <= '0;
`endif
        end
        CALC: begin
          root_q <= root_nxt;
          if (b_q != '0) b_q <= b_q - BW'(1);
`ifdef SQRT_ARB_REMAINDER_EN
          else rem_q <= rem_full[RW:0];
`endif
        end
        DONE: if (res_ready)
          ptr_q <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_root  = root_q;
  assign res_id    = id_q;
  assign res_neg   = neg_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: unsigned instance for arbitration/latency, TC_MODE=1 instance for sign handling.
module tb_sqrt_arbiter;
  localparam int W = 8, N = 4, RW = 4, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           res_valid, res_ready, res_neg;
  logic [RW-1:0]  res_root;
  logic [IDW-1:0] res_id;

  logic [N-1:0]   tc_valid, tc_ready;
  logic [N*W-1:0] tc_data;
  logic           tc_res_valid, tc_res_ready, tc_neg;
  logic [RW-1:0]  tc_root;
  logic [IDW-1:0] tc_id;
`ifdef SQRT_ARB_REMAINDER_EN
  logic [RW:0]    res_rem, tc_rem;
`endif

  sqrt_arbiter #(.WIDTH(W), .NUM_REQ(N), .TC_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_root(res_root), .res_id(res_id), .res_neg(res_neg)
`ifdef SQRT_ARB_REMAINDER_EN
    , .res_rem(res_rem)
`endif
  );

  sqrt_arbiter #(.WIDTH(W), .NUM_REQ(N), .TC_MODE(1)) dut_tc (
    .clk(clk), .rst_n(rst_n), .req_valid(tc_valid), .req_data(tc_data),
    .req_ready(tc_ready), .res_valid(tc_res_valid), .res_ready(tc_res_ready),
    .res_root(tc_root), .res_id(tc_id), .res_neg(tc_neg)
`ifdef SQRT_ARB_REMAINDER_EN
    , .res_rem(tc_rem)
`endif
  );

  int errors = 0, checks = 0;
  logic         auto_drop;
  logic [N-1:0] seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; records grants and optionally withdraws accepted requests.
  task automatic step();
    logic [N-1:0] acc;
    #1;
    acc  = req_valid & req_ready;
    seen = seen | acc;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, " timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic take(input string tag, input int id, input int root, input int rem);
    wait_res(tag);
    chk({tag, " id"}, 32'(res_id), 32'(id));
    chk({tag, " root"}, 32'(res_root), 32'(root));
`ifdef SQRT_ARB_REMAINDER_EN
    chk({tag, " rem"}, 32'(res_rem), 32'(rem));
`endif
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0;
    tc_valid = '0; tc_data = '0; tc_res_ready = 1'b0; seen = '0; auto_drop = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state and single operand 200
    do_reset();
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst root", 32'(res_root), 32'd0);
    chk("rst id", 32'(res_id), 32'd0);
    chk("rst neg", 32'(res_neg), 32'd0);
    req_data[7:0] = 8'd200;
    req_valid[0]  = 1'b1;
    #1 chk("t1 grant", 32'(req_ready), 32'd1);
    step();
    repeat (3) step();
    chk("t1 early valid", 32'(res_valid), 32'd0);
    step();
    chk("t1 valid@4", 32'(res_valid), 32'd1);
    take("t1", 0, 14, 4);
    chk("t1 valid after hs", 32'(res_valid), 32'd0);

    // four simultaneous requests
    do_reset();
    req_data  = {8'd144, 8'd255, 8'd1, 8'd0};
    req_valid = 4'hF;
    take("t2a", 0, 0, 0);
    take("t2b", 1, 1, 0);
    take("t2c", 2, 15, 30);
    take("t2d", 3, 12, 0);

    // two requesters held valid continuously
    do_reset();
    auto_drop = 1'b0;
    req_data  = {8'd0, 8'd100, 8'd0, 8'd81};
    req_valid = 4'b0101;
    take("t3a", 0, 9, 0);
    take("t3b", 2, 10, 0);
    take("t3c", 0, 9, 0);
    take("t3d", 2, 10, 0);
    chk("t3 grants seen", 32'(seen), 32'h5);

    // back-pressure with another requester waiting
    do_reset();
    req_data  = {8'd0, 8'd0, 8'd9, 8'd200};
    req_valid = 4'b0011;
    wait_res("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4 hold valid", 32'(res_valid), 32'd1);
      chk("t4 hold root", 32'(res_root), 32'd14);
      chk("t4 hold id", 32'(res_id), 32'd0);
      chk("t4 no grant", 32'(req_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t4 released", 32'(res_valid), 32'd0);
    chk("t4 next grant", 32'(req_ready), 32'h2);
    take("t4b", 1, 3, 0);

    // two's-complement instance
    do_reset();
    tc_data[7:0] = 8'hF0;
    tc_valid[0]  = 1'b1;
    #1 chk("t5 grant", 32'(tc_ready), 32'd1);
    @(posedge clk); #1;
    tc_valid = '0;
    chk("t5 neg valid@1", 32'(tc_res_valid), 32'd1);
    chk("t5 neg flag", 32'(tc_neg), 32'd1);
    chk("t5 neg root", 32'(tc_root), 32'd0);
`ifdef SQRT_ARB_REMAINDER_EN
    chk("t5 neg rem", 32'(tc_rem), 32'd0);
`endif
    tc_res_ready = 1'b1;
    @(posedge clk); #1;
    tc_res_ready = 1'b0;
    chk("t5 released", 32'(tc_res_valid), 32'd0);
    tc_data[7:0] = 8'h40;
    tc_valid[0]  = 1'b1;
    @(posedge clk); #1;
    tc_valid = '0;
    repeat (3) @(posedge clk);
    #1 chk("t5 pos early", 32'(tc_res_valid), 32'd0);
    @(posedge clk); #1;
    chk("t5 pos valid", 32'(tc_res_valid), 32'd1);
    chk("t5 pos root", 32'(tc_root), 32'd8);
    chk("t5 pos neg", 32'(tc_neg), 32'd0);

    // asynchronous reset during the second CALC cycle
    do_reset();
    auto_drop     = 1'b0;
    req_data[7:0] = 8'd200;
    req_valid[0]  = 1'b1;
    step();
    step();
    chk("t6 partial root", 32'(res_root), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("t6 rst req_ready", 32'(req_ready), 32'd0);
    chk("t6 rst valid", 32'(res_valid), 32'd0);
    chk("t6 rst root", 32'(res_root), 32'd0);
    chk("t6 rst id", 32'(res_id), 32'd0);
    chk("t6 rst neg", 32'(res_neg), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    auto_drop = 1'b1;
    take("t6", 0, 14, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Multi-cycle square-root engine shared by `NUM_REQ` requesters through a round-robin arbiter with valid/ready handshakes on both sides. It uses the restoring set-bit-and-compare method, one result bit per cycle, so a single squarer/comparator replaces a fully unrolled combinational root. It sits between the HPS-facing register/FIFO logic and any fabric clients that need integer roots.

## Interface
- `WIDTH`, 8, operand width in bits; root width `RW = (WIDTH+1)/2`
- `NUM_REQ`, 4, number of requesters (≥2); `IDW = $clog2(NUM_REQ)`
- `TC_MODE`, 0, 0 = unsigned operands, 1 = two's-complement operands

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester request
- `req_data`  in  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NUM_REQ  one-hot grant; operand i is accepted on a clock edge with `req_valid[i] & req_ready[i]`
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumer ready
- `res_root`  out  RW  floor(sqrt(operand))
- `res_id`  out  IDW  index of the requester that owns the result
- `res_neg`  out  1  TC_MODE=1 only: operand was negative; tied 0 when TC_MODE=0
- `res_rem`  out  RW+1  operand − root², present only with `SQRT_ARB_REMAINDER_EN`

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - Grant the first `req_valid[k]`, searching k = ptr, ptr+1, … modulo NUM_REQ.
  - `req_ready` is combinational and one-hot on the grant. It is 0 outside IDLE and while `rst_n` is low.
  - On acceptance, latch operand A and id k, clear the root register, and set bit index b = RW−1.
  - Next state is CALC. With TC_MODE=1 and A[WIDTH−1]=1, next state is DONE instead, with root=0 and neg=1.
- CALC, once per cycle:
  - Compute trial = root | (1<<b).
  - If trial·trial ≤ {0,A}, root ← trial.
  - Compare at 2·RW bits, which is wide enough that overflow cannot occur.
  - If b==0, go to DONE; otherwise b ← b−1.
- DONE:
  - `res_valid`=1; `res_root`, `res_id`, `res_neg`, `res_rem` are held stable.
  - On `res_valid & res_ready`: ptr ← (id+1) mod NUM_REQ, go to IDLE.
- Requesters hold `req_valid` and their data until accepted. A withdrawn request is simply not granted, and the grant is recomputed every IDLE cycle.
- Unknown (x) operand bits propagate x to `res_root`. This is not a checked behaviour.
- Reset values: `req_ready`=0, `res_valid`=0, `res_root`=0, `res_id`=0, `res_neg`=0, `res_rem`=0, ptr=0.

## Timing
- Latency:
  - Acceptance edge E. `res_valid` rises after edge E+RW, i.e. RW cycles; 4 for WIDTH=8.
  - Negative TC operand: `res_valid` rises after edge E+1.
- Throughput: one result per RW+2 cycles at best (accept, RW CALC, DONE handshake). IDLE can grant on the cycle after the DONE handshake edge.
- Back-pressure: DONE holds indefinitely while `res_ready`=0, and no requester is granted.
- Ties:
  - Simultaneous requests are resolved by the rotating pointer. No requester waits more than NUM_REQ−1 services.
  - `req_valid` rising in the same cycle as a grant elsewhere is not accepted in that cycle.
- Reset mid-operation: asynchronous return to IDLE, all outputs cleared immediately, ptr=0. The in-flight result is lost and the requester must re-request.

## Configuration
- `SQRT_ARB_REMAINDER_EN` defined:
  - Adds the `res_rem` port and a RW+1-bit remainder register, loaded on the last CALC step.
  - For negative TC operands, `res_rem`=0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Default parameters. Requester 0 submits 200 → grant 0, `res_valid` 4 cycles after acceptance, root 14, id 0, rem 4.
- All four requesters present 0, 1, 255, 144 simultaneously with ptr=0 → served in order id 0, 1, 2, 3 with roots 0, 1, 15, 12; `res_rem` 0, 0, 30, 0.
- Requesters 0 and 2 held valid continuously (operands 81, 100) → grants alternate 0, 2, 0, 2; roots 9, 10; requesters 1 and 3 never granted.
- `res_ready` held 0 for 5 cycles on result 14 → `res_valid`, root, id stable throughout; `req_ready` all 0; completes on the first cycle `res_ready`=1.
- TC_MODE=1: operand 8'hF0 → `res_neg`=1, root 0, `res_valid` 1 cycle after acceptance; operand 8'h40 → root 8, `res_neg`=0.
- Assert `rst_n`=0 in the second CALC cycle of operand 200 → all outputs 0 immediately. After release, the still-valid requester is re-granted and yields 14.
